// File: rtl/idli_pkg.sv
// idli_pkg: shared types for the bit-serial IDLI core datapath.
// Data words are 16 bits processed as four 4-bit slices, LSB slice first.
package idli_pkg;

  localparam int unsigned SLICE_W  = 4;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned N_SLICES = DATA_W / SLICE_W;

  typedef logic [SLICE_W-1:0] slice_t;
  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [1:0]         ctr_t;
  typedef logic [1:0]         shamt_t;

  typedef enum logic {
    PIPE_ALU   = 1'b0,
    PIPE_SHIFT = 1'b1
  } pipe_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_AND = 2'd1,
    ALU_OR  = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    SHIFT_SRL = 2'd0,
    SHIFT_SRA = 2'd1,
    SHIFT_ROR = 2'd2,
    SHIFT_ROL = 2'd3
  } shift_op_t;

  // CMP_NV is the spare encoding; it always yields a false predicate.
  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_GE  = 3'd3,
    CMP_LTU = 3'd4,
    CMP_GEU = 3'd5,
    CMP_ANY = 3'd6,
    CMP_NV  = 3'd7
  } cmp_op_t;

  typedef enum logic [1:0] {
    EXEC_IDLE   = 2'd0,
    EXEC_ALU    = 2'd1,
    EXEC_SH_IN  = 2'd2,
    EXEC_SH_OUT = 2'd3
  } exec_state_t;

endpackage

// File: rtl/idli_alu.sv
// idli_alu: one 4-bit ALU slice with optional RHS inversion and carry chaining.
// Logic ops report zero carry-out and zero overflow.
module idli_alu
  import idli_pkg::*;
(
  input  alu_op_t op_i,
  input  logic    inv_i,
  input  slice_t  lhs_i,
  input  slice_t  rhs_i,
  input  logic    carry_i,
  output slice_t  res_o,
  output logic    carry_o,
  output logic    ovf_o
);

  slice_t     rhs_eff;
  logic [4:0] sum;

  assign rhs_eff = inv_i ? ~rhs_i : rhs_i;
  assign sum     = {1'b0, lhs_i} + {1'b0, rhs_eff} + {4'b0000, carry_i};

  always_comb begin
    res_o   = sum[3:0];
    carry_o = 1'b0;
    ovf_o   = 1'b0;
    case (op_i)
      ALU_ADD: begin
        res_o   = sum[3:0];
        carry_o = sum[4];
        ovf_o   = (lhs_i[3] == rhs_eff[3]) && (sum[3] != lhs_i[3]);
      end
      ALU_AND: res_o = lhs_i & rhs_eff;
      ALU_OR:  res_o = lhs_i | rhs_eff;
      ALU_XOR: res_o = lhs_i ^ rhs_eff;
      default: res_o = sum[3:0];
    endcase
  end

endmodule

// File: rtl/idli_exec_seq.sv
// idli_exec_seq: slice-serial execute sequencer for the ALU and shift pipes.
// Define IDLI_EXEC_CMP_EN to include the compare predicate logic.
//
// Handshake: an op transfers on a rising edge where i_op_vld && o_op_rdy;
// o_op_rdy is registered, and op fields are sampled only on that edge.
module idli_exec_seq
  import idli_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_op_vld,
  output logic        o_op_rdy,
  input  pipe_t       i_op_pipe,
  input  alu_op_t     i_op_alu,
  input  logic        i_op_inv,
  input  shift_op_t   i_op_shift,
  input  shamt_t      i_op_shamt,
  input  cmp_op_t     i_op_cmp,
  input  logic        i_op_cmp_en,
  input  slice_t      i_lhs,
  input  slice_t      i_rhs,
  output logic        o_slice_req,
  output ctr_t        o_ctr,
  output logic        o_res_vld,
  output slice_t      o_res,
  output logic        o_pred_vld,
  output logic        o_pred,
  output exec_state_t o_state
);

  exec_state_t state_q, state_d;
  ctr_t        ctr_q, ctr_d;
  logic        rdy_q, rdy_d;
  logic        res_vld_q, res_vld_d;
  slice_t      res_q, res_d;
  logic        accept;

  alu_op_t     alu_q;
  logic        inv_q;
  shift_op_t   shift_q;
  shamt_t      shamt_q;
  logic        carry_q;
  data_t       sh_buf_q;

  slice_t      alu_res;
  logic        alu_cin, alu_cout, alu_ovf;
  logic [4:0]  sh_amt;
  data_t       sh_word;
  slice_t      sh_slice;

  assign accept = i_op_vld && rdy_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= EXEC_IDLE;
      ctr_q     <= '0;
      rdy_q     <= 1'b0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      rdy_q     <= rdy_d;
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
    end
  end

  // Accept is only possible in IDLE or on the last slice of ALU/SH_OUT.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    if (accept) begin
      state_d = (i_op_pipe == PIPE_SHIFT) ? EXEC_SH_IN : EXEC_ALU;
      ctr_d   = '0;
    end else begin
      case (state_q)
        EXEC_IDLE: ctr_d = '0;
        EXEC_SH_IN: begin
          ctr_d = ctr_q + 2'd1;
          if (ctr_q == 2'd3) state_d = EXEC_SH_OUT;
        end
        default: begin
          ctr_d = ctr_q + 2'd1;
          if (ctr_q == 2'd3) state_d = EXEC_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rdy_d       = (state_d == EXEC_IDLE) ||
                  (((state_d == EXEC_ALU) || (state_d == EXEC_SH_OUT)) && (ctr_d == 2'd3));
    res_vld_d   = (state_q == EXEC_ALU) || (state_q == EXEC_SH_OUT);
    o_slice_req = (state_q == EXEC_ALU) || (state_q == EXEC_SH_IN);
    res_d       = '0;
    if (state_q == EXEC_ALU)         res_d = alu_res;
    else if (state_q == EXEC_SH_OUT) res_d = sh_slice;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alu_q   <= ALU_ADD;
      inv_q   <= 1'b0;
      shift_q <= SHIFT_SRL;
      shamt_q <= '0;
    end else if (accept) begin
      alu_q   <= i_op_alu;
      inv_q   <= i_op_inv;
      shift_q <= i_op_shift;
      shamt_q <= i_op_shamt;
    end
  end

  assign alu_cin = (ctr_q == 2'd0) ? inv_q : carry_q;

  idli_alu u_alu (
    .op_i    (alu_q),
    .inv_i   (inv_q),
    .lhs_i   (i_lhs),
    .rhs_i   (i_rhs),
    .carry_i (alu_cin),
    .res_o   (alu_res),
    .carry_o (alu_cout),
    .ovf_o   (alu_ovf)
  );

  // Shift input arrives LSB slice first, so it enters the buffer from the top.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      carry_q  <= 1'b0;
      sh_buf_q <= '0;
    end else begin
      if (state_q == EXEC_ALU)   carry_q  <= alu_cout;
      if (state_q == EXEC_SH_IN) sh_buf_q <= {i_lhs, sh_buf_q[DATA_W-1:SLICE_W]};
    end
  end

  assign sh_amt = {3'b000, shamt_q} + 5'd1;

  always_comb begin
    sh_word = sh_buf_q;
    case (shift_q)
      SHIFT_SRL: sh_word = sh_buf_q >> sh_amt;
      SHIFT_SRA: sh_word = data_t'($signed(sh_buf_q) >>> sh_amt);
      SHIFT_ROR: sh_word = (sh_buf_q >> sh_amt) | (sh_buf_q << (5'd16 - sh_amt));
      SHIFT_ROL: sh_word = (sh_buf_q << sh_amt) | (sh_buf_q >> (5'd16 - sh_amt));
      default:   sh_word = sh_buf_q;
    endcase
  end

  assign sh_slice = sh_word[{ctr_q, 2'b00} +: SLICE_W];

`ifdef IDLI_EXEC_CMP_EN
  cmp_op_t cmp_q;
  logic    cmp_en_q;
  logic    zero_q;
  logic    all_zero, cmp_res, pred_fire;
  logic    pred_vld_q, pred_q;

  always_comb begin
    all_zero  = ((ctr_q == 2'd0) || zero_q) && (alu_res == '0);
    pred_fire = (state_q == EXEC_ALU) && (ctr_q == 2'd3) && cmp_en_q;
    case (cmp_q)
      CMP_EQ:  cmp_res = all_zero;
      CMP_NE:  cmp_res = !all_zero;
      CMP_LT:  cmp_res = alu_res[3] ^ alu_ovf;
      CMP_GE:  cmp_res = !(alu_res[3] ^ alu_ovf);
      CMP_LTU: cmp_res = !alu_cout;
      CMP_GEU: cmp_res = alu_cout;
      CMP_ANY: cmp_res = 1'b1;
      default: cmp_res = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmp_q      <= CMP_EQ;
      cmp_en_q   <= 1'b0;
      zero_q     <= 1'b0;
      pred_vld_q <= 1'b0;
      pred_q     <= 1'b0;
    end else begin
      if (accept) begin
        cmp_q    <= i_op_cmp;
        cmp_en_q <= i_op_cmp_en && (i_op_pipe == PIPE_ALU);
      end
      if (state_q == EXEC_ALU) zero_q <= all_zero;
      pred_vld_q <= pred_fire;
      pred_q     <= pred_fire && cmp_res;
    end
  end

  assign o_pred_vld = pred_vld_q;
  assign o_pred     = pred_q;
`else
  logic unused_cmp;
  assign unused_cmp = ^{i_op_cmp, i_op_cmp_en, alu_ovf};
  assign o_pred_vld = 1'b0;
  assign o_pred     = 1'b0;
`endif

  assign o_op_rdy  = rdy_q;
  assign o_ctr     = ctr_q;
  assign o_res_vld = res_vld_q;
  assign o_res     = res_q;
  assign o_state   = state_q;

endmodule
